// File: rtl/baccarat_datapath.sv
// ============================================================================
// Module   : baccarat_datapath
// Purpose  : Baccarat card source, six card registers and hand-score decode.
//            Define DECK_LFSR_EN to replace the 1..13 counter with an LFSR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module baccarat_datapath (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] next_card,
  output logic [3:0] pcard1_out,
  output logic [3:0] pcard2_out,
  output logic [3:0] pcard3_out,
  output logic [3:0] dcard1_out,
  output logic [3:0] dcard2_out,
  output logic [3:0] dcard3_out,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [3:0] pcard3
);

  localparam logic [3:0] CARD_MAX = 4'd13;

`ifdef DECK_LFSR_EN
  logic [7:0] lfsr;

  // Taps 7,5,4,3 give a maximal-length sequence; seed 1 keeps it off all-zero.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      lfsr <= 8'h01;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign next_card = 4'(lfsr % 8'd13) + 4'd1;
`else
  logic [3:0] card_count;

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      card_count <= 4'd1;
    end else if (card_count == CARD_MAX) begin
      card_count <= 4'd1;
    end else begin
      card_count <= card_count + 4'd1;
    end
  end

  assign next_card = card_count;
`endif

  // Every asserted strobe captures the same card; there is no priority.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      pcard1_out <= 4'd0;
      pcard2_out <= 4'd0;
      pcard3_out <= 4'd0;
      dcard1_out <= 4'd0;
      dcard2_out <= 4'd0;
      dcard3_out <= 4'd0;
    end else begin
      if (load_pcard1) pcard1_out <= next_card;
      if (load_pcard2) pcard2_out <= next_card;
      if (load_pcard3) pcard3_out <= next_card;
      if (load_dcard1) dcard1_out <= next_card;
      if (load_dcard2) dcard2_out <= next_card;
      if (load_dcard3) dcard3_out <= next_card;
    end
  end

  // Ten and face cards count zero, as does an empty slot (raw 0).
  function automatic logic [3:0] card_value(input logic [3:0] raw);
    card_value = (raw <= 4'd9) ? raw : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                            input logic [3:0] c2,
                                            input logic [3:0] c3);
    logic [4:0] sum;
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    if (sum >= 5'd20) begin
      hand_score = 4'(sum - 5'd20);
    end else if (sum >= 5'd10) begin
      hand_score = 4'(sum - 5'd10);
    end else begin
      hand_score = 4'(sum);
    end
  endfunction

  assign pscore = hand_score(pcard1_out, pcard2_out, pcard3_out);
  assign dscore = hand_score(dcard1_out, dcard2_out, dcard3_out);
  assign pcard3 = card_value(pcard3_out);

endmodule

`default_nettype wire
